axi_bram_responder: RTL

- AXI4 responder (memory-side endpoint) for `axi_bus_t`, backed by on-chip block RAM of 512-bit words.
- Terminates bursts from any initiator in the shell/app fabric: DMA engines, app cores, interconnect testbenches.
- Write and read channels run independently and concurrently.
- Used as a scratchpad and as a stand-in memory for DRAM controllers in simulation.

---
 rtl/axi_bram_pkg.sv | 20 ++
 rtl/axi_bus_t.sv | 33 +++
 rtl/axi_bram_skid.sv | 55 +++++
 rtl/axi_bram_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_bram_pkg.sv
// Shared widths, response codes, FSM states and the read-beat record for the
// block-RAM AXI responder.
package axi_bram_pkg;
  localparam int AXI_ID_W   = 16;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 512;
  localparam int BEAT_LSB   = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic                  last;
    logic [AXI_DATA_W-1:0] data;
  } rbeat_t;
endpackage

// File: rtl/axi_bus_t.sv
// AXI4 bus bundle; the master modport is the responder (memory-side) view.
interface axi_bus_t;
  import axi_bram_pkg::*;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/axi_bram_skid.sv
// Two-entry FIFO holding returned read beats so the RAM can keep streaming
// while the initiator stalls rready.
module axi_bram_skid
  import axi_bram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rbeat_t     din,
  input  logic       pop,
  output rbeat_t     dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);
  rbeat_t     ent_q [2];
  rbeat_t     ent_d [2];
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = ent_q[rptr_q];
  assign count   = cnt_q;

  always_comb begin
    ent_d  = ent_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      ent_d[wptr_q] = din;
      wptr_d        = ~wptr_q;
    end
    if (do_pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q  <= ent_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_bram_responder.sv
// AXI4 responder backed by a 512-bit-wide block RAM. Write and read channels
// run independently; read beats stream through a 2-entry skid buffer.
module axi_bram_responder
  import axi_bram_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  axi_bus_t.master s_axi
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = AXI_DATA_W / 8;

  logic [AXI_DATA_W-1:0] mem [DEPTH];
  logic [AXI_DATA_W-1:0] ram_rdata_q;
  logic                  ram_re;
  logic [IDX_W-1:0]      ram_raddr;

  wr_state_e           wst_q, wst_d;
  logic [AXI_ID_W-1:0] wid_q, wid_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                werr_q, werr_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                aw_fire, w_fire, w_final;

  assign aw_fire = s_axi.awvalid & awready_q;
  assign w_fire  = s_axi.wvalid & wready_q;
  assign w_final = (wcnt_q == wlen_q);

  // Burst length comes from awlen alone; wlast only feeds the error flag.
  always_comb begin
    wst_d  = wst_q;
    wid_d  = wid_q;
    widx_d = widx_q;
    wlen_d = wlen_q;
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    case (wst_q)
      W_IDLE: if (aw_fire) begin
        wst_d  = W_DATA;
        wid_d  = s_axi.awid;
        widx_d = s_axi.awaddr[BEAT_LSB +: IDX_W];
        wlen_d = s_axi.awlen;
        wcnt_d = 8'd0;
        werr_d = 1'b0;
      end
      W_DATA: if (w_fire) begin
        widx_d = widx_q + IDX_W'(1);
        wcnt_d = wcnt_q + 8'd1;
        if (s_axi.wlast != w_final) werr_d = 1'b1;
        if (w_final) wst_d = W_RESP;
      end
      W_RESP: if (bvalid_q && s_axi.bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
    awready_d = (wst_d == W_IDLE);
    wready_d  = (wst_d == W_DATA);
    bvalid_d  = (wst_d == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q     <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Non-blocking read and write of the same word gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_axi.wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
    end
    if (ram_re) ram_rdata_q <= mem[ram_raddr];
  end

  rd_state_e           rdst_q, rdst_d;
  logic [AXI_ID_W-1:0] rid_q, rid_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;
  logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic                rbusy_q, rbusy_d, arready_q, arready_d;
  logic                pend_q, pend_d, pend_last_q, pend_last_d;
  logic                ar_fire, r_pop;
  logic [1:0]          rd_slots;
  rbeat_t              sk_din, sk_head;
  logic [1:0]          sk_cnt;
  logic                sk_full, sk_empty;

  assign ar_fire = s_axi.arvalid & arready_q;
  assign r_pop   = ~sk_empty & s_axi.rready;
  // Entry leaving this cycle frees its slot, allowing one beat per cycle.
  assign rd_slots = sk_cnt - 2'(r_pop) + 2'(pend_q);

  always_comb begin
    rdst_d      = rdst_q;
    rid_d       = rid_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    pend_last_d = pend_last_q;
    ram_re      = 1'b0;
    ram_raddr   = ridx_q;
    case (rdst_q)
      R_IDLE: if (ar_fire) begin
        ram_re      = 1'b1;
        ram_raddr   = s_axi.araddr[BEAT_LSB +: IDX_W];
        rid_d       = s_axi.arid;
        rlen_d      = s_axi.arlen;
        rcnt_d      = 8'd1;
        pend_last_d = (s_axi.arlen == 8'd0);
        if (s_axi.arlen != 8'd0) rdst_d = R_BURST;
      end
      R_BURST: if (rd_slots < 2'd2) begin
        ram_re      = 1'b1;
        rcnt_d      = rcnt_q + 8'd1;
        pend_last_d = (rcnt_q == rlen_q);
        if (rcnt_q == rlen_q) rdst_d = R_IDLE;
      end
      default: rdst_d = R_IDLE;
    endcase
    ridx_d  = ram_re ? ram_raddr + IDX_W'(1) : ridx_q;
    pend_d  = ram_re;
    rbusy_d = rbusy_q;
    if (r_pop && sk_head.last) rbusy_d = 1'b0;
    if (ar_fire)               rbusy_d = 1'b1;
    arready_d = (rdst_d == R_IDLE) && !rbusy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdst_q      <= R_IDLE;
      rid_q       <= '0;
      ridx_q      <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      rbusy_q     <= 1'b0;
      arready_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      rdst_q      <= rdst_d;
      rid_q       <= rid_d;
      ridx_q      <= ridx_d;
      rlen_q      <= rlen_d;
      rcnt_q      <= rcnt_d;
      rbusy_q     <= rbusy_d;
      arready_q   <= arready_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign sk_din = '{id: rid_q, last: pend_last_q, data: ram_rdata_q};

  axi_bram_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .din   (sk_din),
    .pop   (r_pop),
    .dout  (sk_head),
    .count (sk_cnt),
    .full  (sk_full),
    .empty (sk_empty)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = wid_q;
  assign s_axi.bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = ~sk_empty;
  assign s_axi.rid     = sk_head.id;
  assign s_axi.rlast   = sk_head.last;
  assign s_axi.rdata   = sk_head.data;
  assign s_axi.rresp   = RESP_OKAY;

  // Offset bits, bits above the index, size and burst type carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[BEAT_LSB-1:0], s_axi.awaddr[AXI_ADDR_W-1:BEAT_LSB+IDX_W],
                         s_axi.araddr[BEAT_LSB-1:0], s_axi.araddr[AXI_ADDR_W-1:BEAT_LSB+IDX_W],
                         s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst, sk_full};
endmodule
